// File: rtl/cmm_pkg.sv
// Shared types for the complex matrix multiplier and its operand loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmm_pkg;

  localparam int ELEM_WIDTH     = 19;
  localparam int N_ELEMS        = 16;
  localparam int BYTES_PER_ELEM = 3;
  localparam int ASM_BITS       = 8 * BYTES_PER_ELEM;

  typedef logic signed [ELEM_WIDTH-1:0] elem_t;

  typedef enum logic [2:0] {
    SYNC,
    COLLECT,
    EMIT,
    FINISH,
    WAIT_DONE
  } loader_state_e;

  // Element index order is {operand,row,col,imag}, imag toggling fastest:
  // A00r, A00i, A01r, A01i, A10r, ... B11i.
  typedef struct packed {
    logic operand;
    logic row;
    logic col;
    logic imag;
  } elem_tag_t;

  function automatic elem_tag_t idx_to_tag(input logic [3:0] idx);
    return elem_tag_t'(idx);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs little-endian bytes into a 24-bit word and range-checks it as a WIDTH-bit signed value.
// Latency: a byte appears in the word one cycle after byte_vld_i.
// Backpressure: none; every byte presented with byte_vld_i is taken.
module byte_word_assembler
  import cmm_pkg::*;
#(
  parameter int WIDTH = ELEM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_dat_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] elem_o,
  output logic             in_range_o
);

  logic [ASM_BITS-1:0] word_q, word_d;
  logic [1:0]          cnt_q, cnt_d;

  // Shift new bytes in from the top so the first byte ends up as the LSB;
  // a clear that coincides with a byte counts that byte as byte 0.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (byte_vld_i) begin
      word_d = {byte_dat_i, word_q[ASM_BITS-1:8]};
    end
    if (clear_i) begin
      cnt_d = byte_vld_i ? 2'd1 : 2'd0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Assembly and byte-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign elem_o     = word_q[WIDTH-1:0];
  // Sign extension is valid only if everything from the sign bit up agrees.
  assign in_range_o = (&word_q[ASM_BITS-1:WIDTH-1]) | ~(|word_q[ASM_BITS-1:WIDTH-1]);

endmodule

// File: rtl/operand_stream_loader.sv
// Frames a UART byte stream into 16 tagged signed elements for the matrix multiplier.
// Latency: in_ready two cycles after an element's 3rd byte; in_finished one cycle after the 16th.
// Backpressure: none upstream; bytes arriving while waiting for mult_done are dropped and flagged.
module operand_stream_loader
  import cmm_pkg::*;
#(
  parameter int         WIDTH          = ELEM_WIDTH,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             mult_done,
  output logic [WIDTH-1:0] matrix_in,
  output logic             imag,
  output logic             row,
  output logic             col,
  output logic             operand,
  output logic             in_ready,
  output logic             in_finished,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  loader_state_e    state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0] matrix_q;
  elem_tag_t        tag_q;
  logic             in_ready_q, in_ready_d;
  logic             in_finished_q, in_finished_d;
  logic             frame_error_q, frame_error_d;
  logic             overrun_q, overrun_d;
  logic             load;

  logic             asm_clr, asm_vld, asm_in_range;
  logic [1:0]       asm_cnt;
  logic [WIDTH-1:0] asm_elem;

  byte_word_assembler #(
    .WIDTH(WIDTH)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (asm_clr),
    .byte_vld_i(asm_vld),
    .byte_dat_i(rx_data),
    .count_o   (asm_cnt),
    .elem_o    (asm_elem),
    .in_range_o(asm_in_range)
  );

  // Frame FSM: next state, byte routing, strobes and sticky flags.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = '0;
    asm_clr       = 1'b0;
    asm_vld       = 1'b0;
    load          = 1'b0;
    in_ready_d    = 1'b0;
    in_finished_d = 1'b0;
    frame_error_d = frame_error_q;
    overrun_d     = overrun_q;
    case (state_q)
      SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          frame_error_d = 1'b0;
          overrun_d     = 1'b0;
          idx_d         = '0;
          asm_clr       = 1'b1;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        asm_vld = rx_valid;
        if (rx_valid) begin
          if (asm_cnt == 2'(BYTES_PER_ELEM - 1)) begin
            state_d = EMIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_error_d = 1'b1;
          state_d       = SYNC;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      EMIT: begin
        if (!asm_in_range) begin
          frame_error_d = 1'b1;
          state_d       = SYNC;
        end else begin
          load       = 1'b1;
          in_ready_d = 1'b1;
          if (idx_q == 4'(N_ELEMS - 1)) begin
            state_d = FINISH;
          end else begin
            // The word is consumed this cycle, so a byte arriving now
            // safely becomes byte 0 of the next element.
            asm_clr = 1'b1;
            asm_vld = rx_valid;
            idx_d   = idx_q + 4'd1;
            state_d = COLLECT;
          end
        end
      end
      FINISH: begin
        in_finished_d = 1'b1;
        state_d       = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (mult_done) begin
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State, counters, flags, and the element/tag output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      idx_q         <= '0;
      tmo_q         <= '0;
      matrix_q      <= '0;
      tag_q         <= '0;
      in_ready_q    <= 1'b0;
      in_finished_q <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      in_ready_q    <= in_ready_d;
      in_finished_q <= in_finished_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      if (load) begin
        matrix_q <= asm_elem;
        tag_q    <= idx_to_tag(idx_q);
      end
    end
  end

  assign matrix_in   = matrix_q;
  assign operand     = tag_q.operand;
  assign row         = tag_q.row;
  assign col         = tag_q.col;
  assign imag        = tag_q.imag;
  assign in_ready    = in_ready_q;
  assign in_finished = in_finished_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != SYNC);

endmodule

// File: tb/tb_operand_stream_loader.sv
// Directed bench for operand_stream_loader: framing, range limits, timeout, overrun, reset.
// Latency: expectations written against a 2-cycle byte-to-in_ready delay.
// Backpressure: n/a (the loader has none).
module tb_operand_stream_loader;

  localparam int TMO = 40;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mult_done;
  logic signed [18:0] matrix_in;
  logic              imag, row, col, operand;
  logic              in_ready, in_finished, busy, frame_error, overrun;

  operand_stream_loader #(
    .WIDTH         (19),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mult_done  (mult_done),
    .matrix_in  (matrix_in),
    .imag       (imag),
    .row        (row),
    .col        (col),
    .operand    (operand),
    .in_ready   (in_ready),
    .in_finished(in_finished),
    .busy       (busy),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  typedef struct {
    logic signed [18:0] val;
    logic [3:0]         tag;
    int                 t;
  } rec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_t;
  int   third_t [16];
  rec_t rdy_q [$];
  int   fin_q [$];

  // A00r, A00i, A01r, ... B11i
  int vals [16] = '{104176, 159610, -49594, 7, -1, 262143, -262144, 0,
                    12345, -12345, 200000, -200000, 1, -2, 65536, -65536};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_ready) rdy_q.push_back('{matrix_in, {operand, row, col, imag}, cyc});
    if (in_finished) fin_q.push_back(cyc);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_t   = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_elem(input int v, input int gap);
    logic [23:0] w;
    w = v[23:0];
    send_byte(w[7:0]);   idle(gap);
    send_byte(w[15:8]);  idle(gap);
    send_byte(w[23:16]); idle(gap);
  endtask

  task automatic send_frame(input bit rev, input int gap);
    send_byte(8'hA5);
    idle(gap);
    for (int i = 0; i < 16; i++) begin
      send_elem(rev ? vals[15-i] : vals[i], gap);
      third_t[i] = (gap == 0) ? last_t : last_t;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({matrix_in, imag, row, col, operand, in_ready, in_finished, busy, frame_error, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {matrix_in, imag, row, col, operand, in_ready, in_finished, busy, frame_error, overrun});
    end
  endtask

  task automatic test_full_frame;
    logic signed [18:0] e;
    rdy_q.delete(); fin_q.delete();
    send_frame(1'b0, 1);
    idle(4);
    n_checks++;
    if (rdy_q.size() != 16) begin n_fail++; $display("FAIL full_count: got %0d required 16", rdy_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i >= rdy_q.size()) continue;
      e = 19'(vals[i]);
      n_checks++;
      if (rdy_q[i].val !== e) begin n_fail++; $display("FAIL full_val[%0d]: got %0d required %0d", i, rdy_q[i].val, e); end
      n_checks++;
      if (rdy_q[i].tag !== 4'(i)) begin n_fail++; $display("FAIL full_tag[%0d]: got %0d required %0d", i, rdy_q[i].tag, i); end
      n_checks++;
      if (rdy_q[i].t - third_t[i] != 2) begin n_fail++; $display("FAIL full_latency[%0d]: got %0d required 2", i, rdy_q[i].t - third_t[i]); end
    end
    n_checks++;
    if (fin_q.size() != 1) begin n_fail++; $display("FAIL full_fin_count: got %0d required 1", fin_q.size()); end
    else if (rdy_q.size() == 16) begin
      n_checks++;
      if (fin_q[0] != rdy_q[15].t + 1) begin n_fail++; $display("FAIL full_fin_time: got %0d required %0d", fin_q[0], rdy_q[15].t + 1); end
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_wait: got %b required 1", busy); end
  endtask

  task automatic test_overrun;
    send_byte(8'h11);
    idle(2);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", overrun); end
    n_checks++;
    if (rdy_q.size() != 16) begin n_fail++; $display("FAIL ovr_no_ready: got %0d required 16", rdy_q.size()); end
    mult_done = 1'b1;
    idle(1);
    mult_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_done_busy: got %b required 0", busy); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
    send_byte(8'hA5);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b required 0", overrun); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_resync_busy: got %b required 1", busy); end
  endtask

  task automatic test_boundary;
    reset = 1'b1; idle(2); reset = 1'b0;
    rdy_q.delete(); fin_q.delete();
    send_byte(8'hA5);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h03); idle(1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hFC); idle(1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    idle(3);
    n_checks++;
    if (rdy_q.size() != 2) begin n_fail++; $display("FAIL bnd_count: got %0d required 2", rdy_q.size()); end
    else begin
      n_checks++;
      if (rdy_q[0].val !== 19'sd262143) begin n_fail++; $display("FAIL bnd_max: got %0d required 262143", rdy_q[0].val); end
      n_checks++;
      if (rdy_q[1].val !== -19'sd262144) begin n_fail++; $display("FAIL bnd_min: got %0d required -262144", rdy_q[1].val); end
      n_checks++;
      if (rdy_q[1].tag !== 4'd1) begin n_fail++; $display("FAIL bnd_tag: got %0d required 1", rdy_q[1].tag); end
    end
    n_checks++;
    if (frame_error !== 1'b1) begin n_fail++; $display("FAIL bnd_ferr: got %b required 1", frame_error); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bnd_sync: got %b required 0", busy); end
    n_checks++;
    if (matrix_in !== -19'sd262144) begin n_fail++; $display("FAIL bnd_hold: got %0d required -262144", matrix_in); end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5);
    n_checks++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL tmo_sync_clear: got %b required 0", frame_error); end
    // A byte just before expiry restarts the idle count.
    idle(TMO - 2);
    send_byte(8'h01);
    idle(TMO - 1);
    n_checks++;
    if (frame_error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got ferr=%b busy=%b required 0/1", frame_error, busy); end
    idle(1);
    n_checks++;
    if (frame_error !== 1'b1) begin n_fail++; $display("FAIL tmo_ferr: got %b required 1", frame_error); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b required 0", busy); end
    send_byte(8'hA5);
    n_checks++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b required 0", frame_error); end
  endtask

  task automatic test_back_to_back;
    logic signed [18:0] e;
    reset = 1'b1; idle(2); reset = 1'b0;
    rdy_q.delete(); fin_q.delete();
    send_frame(1'b1, 0);
    idle(4);
    n_checks++;
    if (rdy_q.size() != 16) begin n_fail++; $display("FAIL b2b_count: got %0d required 16", rdy_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i >= rdy_q.size()) continue;
      e = 19'(vals[15-i]);
      n_checks++;
      if (rdy_q[i].val !== e) begin n_fail++; $display("FAIL b2b_val[%0d]: got %0d required %0d", i, rdy_q[i].val, e); end
      n_checks++;
      if (rdy_q[i].t - third_t[i] != 2) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d required 2", i, rdy_q[i].t - third_t[i]); end
    end
    n_checks++;
    if (fin_q.size() != 1) begin n_fail++; $display("FAIL b2b_fin: got %0d required 1", fin_q.size()); end
  endtask

  task automatic test_reset_midframe;
    logic signed [18:0] e;
    reset = 1'b1; idle(2); reset = 1'b0;
    rdy_q.delete(); fin_q.delete();
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_elem(vals[i], 0);
    send_byte(8'h12);
    idle(2);
    n_checks++;
    if (rdy_q.size() != 6) begin n_fail++; $display("FAIL rst_partial: got %0d required 6", rdy_q.size()); end
    reset = 1'b1;
    idle(1);
    n_checks++;
    if ({matrix_in, imag, row, col, operand, in_ready, in_finished, busy, frame_error, overrun} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: got %h required 0",
               {matrix_in, imag, row, col, operand, in_ready, in_finished, busy, frame_error, overrun});
    end
    reset = 1'b0;
    rdy_q.delete(); fin_q.delete();
    send_frame(1'b0, 1);
    idle(4);
    n_checks++;
    if (rdy_q.size() != 16) begin n_fail++; $display("FAIL rst_reload_count: got %0d required 16", rdy_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i >= rdy_q.size()) continue;
      e = 19'(vals[i]);
      n_checks++;
      if (rdy_q[i].val !== e || rdy_q[i].tag !== 4'(i)) begin
        n_fail++;
        $display("FAIL rst_reload[%0d]: got %0d/tag %0d required %0d/tag %0d", i, rdy_q[i].val, rdy_q[i].tag, e, i);
      end
    end
    n_checks++;
    if (fin_q.size() != 1) begin n_fail++; $display("FAIL rst_reload_fin: got %0d required 1", fin_q.size()); end
  endtask

  initial begin
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mult_done = 1'b0;
    idle(3);
    test_reset;
    reset = 1'b0;
    idle(2);
    test_full_frame;
    test_overrun;
    test_boundary;
    test_timeout;
    test_back_to_back;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
